clock_period_meter: RTL and testbench
=====================================

# clock_period_meter

Measures the period and high time of a slow, asynchronous clock-like input against the fast system clock. Results are reported in fast-clock cycles. It is the receiving end for the divided clocks produced elsewhere in the design, and is used for on-board checking of divider outputs and of external slow signals. Each new pair of results is flagged with a one-cycle `valid_o` pulse.

## Interface
Parameters:
- `CNT_W`, default 16: width of the cycle counter and of both result outputs. The maximum measurable period is 2^CNT_W−1 cycles.

Ports:
- `clk_i`, input, 1: fast system clock. All logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `sig_i`, input, 1: slow signal being measured. It is asynchronous to `clk_i`.
- `period_o`, output, CNT_W: rising-edge-to-rising-edge period of the last complete cycle, in `clk_i` cycles.
- `high_o`, output, CNT_W: rising-edge-to-falling-edge high time of the same cycle, in `clk_i` cycles.
- `valid_o`, output, 1: one-cycle pulse when `period_o` and `high_o` update.
- `timeout_o`, output, 1: level flag. High when no rising edge arrived within 2^CNT_W−1 cycles.

## Operation
- **Synchronizer:** a 3-flop chain `s1`→`s2`→`s3` on `sig_i`.
  - rise = `s2 & ~s3`
  - fall = `~s2 & s3`
  - No other logic samples `sig_i`.
- **Registers:** counter `cnt`, high-time latch `hi_lat`, and a 2-state FSM.
- **Reset (async, `reset_n`=0):**
  - state = WAIT_EDGE; `cnt`=0; `hi_lat`=0.
  - `period_o`=0, `high_o`=0, `valid_o`=0, `timeout_o`=0.
  - Synchronizer flops = 0.
- **WAIT_EDGE state:**
  - `cnt` holds at 0 and fall is ignored.
  - On rise: `cnt`<=1, go to MEASURE. `valid_o` stays 0 because there is no complete period yet.
- **MEASURE state, every cycle:**
  - Normally `cnt`<=`cnt`+1, saturating at 2^CNT_W−1.
  - On fall: `hi_lat`<=`cnt`. Counting continues.
  - On rise:
    - `period_o`<=`cnt`, `high_o`<=`hi_lat`.
    - `valid_o`<=1 and `timeout_o`<=0.
    - `cnt`<=1, so the rise cycle counts as cycle 1 of the next period.
    - Stay in MEASURE.
  - On no rise with `cnt`==2^CNT_W−1:
    - `timeout_o`<=1, `cnt`<=0, go to WAIT_EDGE.
    - `period_o` and `high_o` hold their last values.
- **Arithmetic:** for a synchronized waveform with period P and high time H (P ≤ 2^CNT_W−1, 0<H<P), the block reports `period_o`=P and `high_o`=H exactly.
- **Boundary cases:**
  - A rise in the same cycle that `cnt` reaches max wins: it is reported as a valid period of 2^CNT_W−1 and `timeout_o` is not set.
  - If no fall was seen since the last rise, `high_o` reports the `hi_lat` value carried from the previous period.
  - `timeout_o` stays high until the next `valid_o` pulse. The first rise after a timeout only restarts measurement.
  - Reset asserted mid-measurement discards the partial count. The first valid after reset needs two rises.

## Timing
- Synchronizer latency: a `sig_i` transition first captured by `s1` at edge k appears on `s2` at edge k+1. Rise/fall are decoded in the cycle after k+1.
- Result latency: `period_o`, `high_o` and `valid_o` update at edge k+2 relative to the `s1` capture of the rising edge.
- `valid_o` is high for exactly one cycle per measured period. It is never high in two consecutive cycles unless P=1, which is out of spec: the minimum supported P is 4 with H≥2 and P−H≥2.
- `timeout_o` sets at the edge where `cnt` would exceed max. It clears at the same edge that raises `valid_o`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** hold `reset_n`=0 for 5 cycles with `sig_i` toggling. Required: all outputs stay 0 throughout, then remain 0 until the second rise after release.
- **Square wave:** P=10, H=4, 5 periods. Required:
  - First `valid_o` occurs 2 edges after the second captured rise, with `period_o`=10 and `high_o`=4.
  - Then one pulse every 10 cycles.
  - `timeout_o`=0 throughout.
- **Divider-style input:** P=10002, H=5001. Required: `period_o`=10002, `high_o`=5001 on every pulse after the first.
- **Timeout (CNT_W=8):** one rise, then `sig_i` held low. Required:
  - `timeout_o`=1 exactly 255 cycles after the rise is decoded, with no `valid_o`.
  - Then apply P=20, H=10. The first valid arrives after two rises, reporting 20/10, and `timeout_o` drops at that same edge.
- **Period change:** switch from P=10/H=5 to P=16/H=8 at a rising edge. Required: consecutive pulses report 10/5, then 16/8, with no intermediate value.
- **Reset mid-measurement:** pulse `reset_n` low for 1 cycle at `cnt`≈6 during a P=12 wave. Required: outputs return to 0 immediately, with no `valid_o` until the second rise after release, which reports 12.

Source files
------------

// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
//
// Measures the period and high time of a slow, asynchronous clock-like input
// in cycles of the fast system clock. A fresh result pair is flagged with a
// single-cycle valid pulse. If no rising edge arrives within the counter
// range, a sticky timeout flag is raised until the next valid result.
//
// Ports:
//   clk_i        fast system clock, all logic on its rising edge
//   reset_n      asynchronous active-low reset
//   sig_i        slow signal under measurement, asynchronous to clk_i
//   period_o     rise-to-rise period of the last complete cycle
//   high_o       rise-to-fall high time of that same cycle
//   valid_o      one-cycle pulse when period_o/high_o update
//   timeout_o    level flag, no rising edge within 2^CNT_W-1 cycles
//   dbg_state_o  FSM state (0 = WAIT_EDGE, 1 = MEASURE)
//
// Handshake: valid_o is a pure strobe with no ready/backpressure. The result
// pair on period_o/high_o is meaningful in the cycle valid_o is high and is
// held stable until the next valid_o pulse.
// -----------------------------------------------------------------------------
module clock_period_meter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_n,
   input  logic             sig_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             timeout_o,
   output logic             dbg_state_o
);

   typedef enum logic {
      WAIT_EDGE = 1'b0,
      MEASURE   = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic             w_rise;
   logic             w_fall;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_hi_lat;
   logic [CNT_W-1:0] w_hi_lat_nxt;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] w_period_nxt;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] w_high_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;

   // Three-flop synchronizer; s1 may go metastable, edges are decoded
   // from the settled s2/s3 pair only.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= sig_i;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= WAIT_EDGE;
         r_cnt     <= '0;
         r_hi_lat  <= '0;
         r_period  <= '0;
         r_high    <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hi_lat  <= w_hi_lat_nxt;
         r_period  <= w_period_nxt;
         r_high    <= w_high_nxt;
         r_valid   <= w_valid_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_hi_lat_nxt  = r_hi_lat;
      w_period_nxt  = r_period;
      w_high_nxt    = r_high;
      w_valid_nxt   = 1'b0;
      w_timeout_nxt = r_timeout;

      if (r_state == WAIT_EDGE) begin
         // Idle until the first rise; falls carry no information yet.
         w_cnt_nxt = '0;
         if (w_rise) begin
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = MEASURE;
         end
      end else begin
         if (w_fall) begin
            w_hi_lat_nxt = r_cnt;
         end
         if (w_rise) begin
            // A rise takes priority over the counter limit, so a period of
            // exactly CNT_MAX is still reported. The rise cycle itself is
            // cycle 1 of the next period.
            w_period_nxt  = r_cnt;
            w_high_nxt    = r_hi_lat;
            w_valid_nxt   = 1'b1;
            w_timeout_nxt = 1'b0;
            w_cnt_nxt     = CNT_ONE;
         end else if (r_cnt == CNT_MAX) begin
            // Counter would overflow: give up on this period and wait for
            // a fresh rise. Results keep their last values.
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = WAIT_EDGE;
         end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
         end
      end
   end

   assign period_o    = r_period;
   assign high_o      = r_high;
   assign valid_o     = r_valid;
   assign timeout_o   = r_timeout;
   assign dbg_state_o = (r_state == MEASURE);

endmodule

// File: tb/tb_clock_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_period_meter
//
// Two instances share one stimulus: a 16-bit meter and an 8-bit meter (whose
// 255-cycle limit makes timeouts reachable). The reference model works on
// edge timestamps: a result is the distance between successive rise times and
// the distance from a rise to the latest fall, with a rise arriving more than
// the counter limit after its predecessor treated as a timeout/restart.
// -----------------------------------------------------------------------------
module tb_clock_period_meter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sig = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] p16, h16;
  logic        v16, t16, st16;
  logic [7:0]  p8, h8;
  logic        v8, t8, st8;

  clock_period_meter #(.CNT_W(16)) dut16 (
    .clk_i(clk), .reset_n(reset_n), .sig_i(sig),
    .period_o(p16), .high_o(h16), .valid_o(v16), .timeout_o(t16),
    .dbg_state_o(st16)
  );

  clock_period_meter #(.CNT_W(8)) dut8 (
    .clk_i(clk), .reset_n(reset_n), .sig_i(sig),
    .period_o(p8), .high_o(h8), .valid_o(v8), .timeout_o(t8),
    .dbg_state_o(st8)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int nval16 = 0;
  int nval8 = 0;
  int first_val16 = -1;
  int to_cyc8 = -1;
  int first_val8_to = -1;
  int to_before_val8 = -1;
  logic prev_t8 = 1'b0;
  int rise_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // index 0 -> 16-bit instance, index 1 -> 8-bit instance
  int  max_c [2] = '{65535, 255};
  bit  meas   [2];
  int  t_rise [2];
  int  hi_last[2];
  int  e_per  [2];
  int  e_hi   [2];
  bit  e_val  [2];
  bit  e_to   [2];
  // sig level as seen by the meter, one entry per cycle, newest at the back
  bit  hist[$];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      meas[i] = 1'b0; t_rise[i] = 0; hi_last[i] = 0;
      e_per[i] = 0; e_hi[i] = 0; e_val[i] = 1'b0; e_to[i] = 1'b0;
    end
    hist = '{1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  // Evaluated at each active edge: a level driven after edge n is acted upon
  // at edge n+3 (two synchronizer stages plus the result register).
  function automatic void model_step();
    bit x, px;
    x  = hist[hist.size()-3];
    px = hist[hist.size()-4];
    for (int i = 0; i < 2; i++) begin
      e_val[i] = 1'b0;
      if (x && !px) begin
        if (meas[i]) begin
          e_per[i] = cyc - t_rise[i];
          e_hi[i]  = hi_last[i];
          e_val[i] = 1'b1;
          e_to[i]  = 1'b0;
        end
        meas[i]   = 1'b1;
        t_rise[i] = cyc;
      end else if (meas[i]) begin
        if (!x && px) hi_last[i] = cyc - t_rise[i];
        if (cyc - t_rise[i] == max_c[i]) begin
          e_to[i] = 1'b1;
          meas[i] = 1'b0;
        end
      end
    end
    while (hist.size() > 8) void'(hist.pop_front());
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of stimulus just after an active edge, compares every
  // output against the model on the falling edge, then advances the model.
  task automatic cycle(input logic s, input logic rn);
    sig = s;
    reset_n = rn;
    if (!rn) model_reset();
    else hist.push_back(s);
    @(negedge clk);
    check("period16", p16, e_per[0]);
    check("high16", h16, e_hi[0]);
    check("valid16", v16, e_val[0]);
    check("timeout16", t16, e_to[0]);
    check("period8", p8, e_per[1]);
    check("high8", h8, e_hi[1]);
    check("valid8", v8, e_val[1]);
    check("timeout8", t8, e_to[1]);
    if (v16) begin
      nval16++;
      if (first_val16 < 0) first_val16 = cyc;
    end
    if (v8) begin
      nval8++;
      if (first_val8_to < 0) begin
        first_val8_to  = t8;
        to_before_val8 = prev_t8;
      end
    end
    if (t8 === 1'b1 && prev_t8 === 1'b0 && to_cyc8 < 0) to_cyc8 = cyc;
    prev_t8 = t8;
    @(posedge clk);
    cyc++;
    if (reset_n) model_step();
    #1;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      rise_cyc.push_back(cyc);
      for (int j = 0; j < h; j++) cycle(1'b1, 1'b1);
      for (int j = 0; j < p - h; j++) cycle(1'b0, 1'b1);
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int p; int h; int n;
    int e16_p; int e16_h;
    int e8_p; int e8_h; bit e8_to;
  } row_t;

  row_t rows[9];

  initial begin
    int nv0;
    int rp, rh, rcyc;

    rows[0] = '{10,    4,    5, 10,    4,    10,  4,   1'b0};
    rows[1] = '{10,    5,    3, 10,    5,    10,  5,   1'b0};
    rows[2] = '{16,    8,    3, 16,    8,    16,  8,   1'b0};
    rows[3] = '{4,     2,    4, 4,     2,    4,   2,   1'b0};
    rows[4] = '{7,     5,    4, 7,     5,    7,   5,   1'b0};
    rows[5] = '{255,   100,  3, 255,   100,  255, 100, 1'b0};
    rows[6] = '{256,   128,  3, 256,   128,  255, 100, 1'b1};
    rows[7] = '{20,    10,   3, 20,    10,   20,  10,  1'b0};
    rows[8] = '{10002, 5001, 3, 10002, 5001, 20,  10,  1'b1};

    model_reset();

    // Reset held with sig toggling: everything stays at zero.
    for (int i = 0; i < 5; i++) cycle(logic'(i % 2), 1'b0);
    check("rst_period", p16, 0);
    check("rst_high", h16, 0);
    check("rst_valid", v16, 0);
    check("rst_timeout", t16, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

    nval16 = 0;
    first_val16 = -1;
    rise_cyc.delete();

    // Table: each row continues the waveform from the previous one.
    for (int r = 0; r < 9; r++) begin
      nv0 = nval16;
      wave(rows[r].p, rows[r].h, rows[r].n);
      check($sformatf("row%0d_period16", r), p16, rows[r].e16_p);
      check($sformatf("row%0d_high16", r), h16, rows[r].e16_h);
      check($sformatf("row%0d_timeout16", r), t16, 0);
      check($sformatf("row%0d_valids16", r), nval16 - nv0,
            (r == 0) ? rows[r].n - 1 : rows[r].n);
      check($sformatf("row%0d_period8", r), p8, rows[r].e8_p);
      check($sformatf("row%0d_high8", r), h8, rows[r].e8_h);
      check($sformatf("row%0d_timeout8", r), t8, rows[r].e8_to);
      if (r == 0) check("first_valid_latency", first_val16, rise_cyc[1] + 3);
    end

    // Timeout on the 8-bit meter: one rise, then held low.
    do_reset();
    nval8 = 0;
    to_cyc8 = -1;
    first_val8_to = -1;
    rcyc = cyc;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1);
    check("to_latency", to_cyc8, rcyc + 3 + 255);
    check("to_no_valid", nval8, 0);
    check("to_level", t8, 1);
    wave(20, 10, 3);
    check("to_recover_valids", nval8, 2);
    check("to_recover_period", p8, 20);
    check("to_recover_high", h8, 10);
    check("to_recover_timeout", t8, 0);
    check("to_clear_with_valid", first_val8_to, 0);
    check("to_set_before_valid", to_before_val8, 1);

    // Reset pulse in the middle of a P=12 period (sig low at the time).
    wave(12, 4, 2);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("midrst_period", p16, 0);
    check("midrst_high", h16, 0);
    check("midrst_valid", v16, 0);
    nval16 = 0;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    wave(12, 4, 1);
    check("midrst_no_valid_first_rise", nval16, 0);
    wave(12, 4, 2);
    check("midrst_valids", nval16, 2);
    check("midrst_period12", p16, 12);
    check("midrst_high4", h16, 4);

    // Random periods; the model checks every cycle, and the last period is
    // also checked explicitly after a closing rise.
    rp = 4;
    rh = 2;
    for (int k = 0; k < 25; k++) begin
      rp = $urandom_range(400, 4);
      rh = $urandom_range(rp - 2, 2);
      wave(rp, rh, 1);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    check("rand_last_period16", p16, rp);
    check("rand_last_high16", h16, rh);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
